data_memory_responder: RTL and testbench
========================================

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data and address width.
REQ-002 SHALL have parameter DEPTH, default 256: number of 32-bit words in the backing array.
REQ-003 SHALL have parameter LATENCY, default 2: stall cycles per access; legal range 1..15.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port MemRead  input  1  load request from datapath.
REQ-007 SHALL have port MemWrite  input  1  store request from datapath.
REQ-008 SHALL have port Size  input  3  RISC-V funct3: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
REQ-009 SHALL have port Addr  input  WIDTH  byte address (datapath ALUResult).
REQ-010 SHALL have port WriteData  input  WIDTH  store data, right-aligned.
REQ-011 SHALL have port ReadData  output  WIDTH  load result, extended per Size.
REQ-012 SHALL have port stall  output  1  high freezes the datapath PC.
REQ-013 SHALL have port Fault  output  1  one-cycle pulse on a rejected access.

Function
REQ-014 SHALL implement the FSM states IDLE, WAIT and DONE.
REQ-015 In IDLE, req = MemRead|MemWrite; stall SHALL equal req combinationally, so the PC holds in the request cycle.
REQ-016 In IDLE with req, the edge SHALL capture Addr, WriteData, Size and op, and load cnt = LATENCY-1.
REQ-017 From IDLE with req, next state SHALL be DONE if LATENCY==1, else WAIT.
REQ-018 In WAIT: stall=1; cnt decrements each cycle; on the edge where cnt==1, next state is DONE.
REQ-019 stall SHALL be high for exactly LATENCY consecutive cycles per access.
REQ-020 Access commit SHALL occur on the edge entering DONE: store updates the array; load registers ReadData.
REQ-021 In DONE: stall=0; next state SHALL be IDLE unconditionally; request inputs are ignored, so a held request is not re-accepted.
REQ-022 Inputs SHALL be ignored in WAIT and DONE; captured values govern the access.
REQ-023 Storage SHALL be little-endian; word index = Addr[log2(DEPTH)+1:2], wrapping modulo DEPTH.
REQ-024 Stores: SB writes byte Addr[1:0]; SH writes bytes Addr[1]*2..+1; SW writes all 4 bytes; other bytes unchanged.
REQ-025 Loads: LB/LH sign-extend; LBU/LHU zero-extend; LW returns the full word.
REQ-026 A rejected access (half at odd Addr, word with Addr[1:0]!=0, unsupported Size, or MemRead&MemWrite both high) SHALL still stall LATENCY cycles.
REQ-027 A rejected access SHALL leave the array unchanged, set ReadData=0, and assert Fault for the DONE cycle only.
REQ-028 ReadData SHALL change only at load commit or reset; stores leave it unchanged.
REQ-029 Fault SHALL be 0 in every cycle except the DONE cycle of a rejected access.

Reset
REQ-030 On reset assertion (any cycle, including mid-access): state=IDLE, cnt=0, ReadData=0, Fault=0; stall then follows REQ-015.
REQ-031 A store interrupted by reset before reaching DONE SHALL NOT modify the array.
REQ-032 Array contents SHALL NOT be cleared by reset.

Verification
REQ-033 LATENCY=2, SW Addr=0x10 WriteData=0xDEADBEEF -> stall high 2 cycles, then DONE. A following LW 0x10 -> ReadData=0xDEADBEEF in its DONE cycle.
REQ-034 After REQ-033: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
REQ-035 Store SB 0x11 data 0x55 then LW 0x10 -> 0xDEAD55EF.
REQ-036 LW Addr=0x12 -> stall 2 cycles, Fault pulses 1 cycle, ReadData=0. A subsequent LW 0x10 returns the unchanged value.
REQ-037 LATENCY=3, SW 0x20=0x12345678 with reset pulsed in the 2nd stall cycle -> stall drops and state=IDLE; LW 0x20 returns the pre-existing contents.
REQ-038 Request held high through DONE and the following cycle -> second access begins exactly one cycle after DONE. Addr=4*DEPTH+8 aliases word 2.

Source files
------------

// File: rtl/data_memory_responder.sv
// data_memory_responder
//   Byte-addressed, little-endian data memory for a RISC-V style datapath.
//   Every access (load or store) stalls the datapath for exactly LATENCY
//   cycles, then completes in a one-cycle DONE state. Misaligned,
//   unsupported or conflicting (read+write) requests are rejected: the
//   array is untouched, ReadData is cleared and Fault pulses in DONE.
//
// Parameters
//   WIDTH   : data/address width (>= 32)
//   DEPTH   : number of 32-bit words in the array (power of two)
//   LATENCY : stall cycles per access, 1..15
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   MemRead   in   load request
//   MemWrite  in   store request
//   Size      in   funct3 access size (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   Addr      in   byte address
//   WriteData in   store data, right-aligned
//   ReadData  out  load result, extended per Size
//   stall     out  holds the datapath PC while high
//   Fault     out  one-cycle pulse in DONE of a rejected access
module data_memory_responder #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             MemRead,
   input  logic             MemWrite,
   input  logic [2:0]       Size,
   input  logic [WIDTH-1:0] Addr,
   input  logic [WIDTH-1:0] WriteData,
   output logic [WIDTH-1:0] ReadData,
   output logic             stall,
   output logic             Fault
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t           state, state_nxt;
   logic [3:0]       cnt, cnt_nxt;
   logic             req;
   logic             commit;

   logic [WIDTH-1:0] addr_q, wdata_q;
   logic [2:0]       size_q;
   logic             rd_q, wr_q;

   logic [WIDTH-1:0] acc_addr, acc_wdata;
   logic [2:0]       acc_size;
   logic             acc_rd, acc_wr, acc_bad;
   logic [AW-1:0]    acc_idx;
   logic [1:0]       acc_off;
   logic [31:0]      acc_word;
   logic             unused_bits;

   logic [31:0]      mem [DEPTH];

   function automatic logic is_bad(input logic rd, input logic wr,
                                   input logic [2:0] sz, input logic [1:0] off);
      logic bad;
      case (sz)
         3'b000, 3'b100: bad = 1'b0;
         3'b001, 3'b101: bad = off[0];
         3'b010:         bad = (off != 2'b00);
         default:        bad = 1'b1;
      endcase
      // Unsigned variants exist only for loads.
      if (wr && sz[2]) bad = 1'b1;
      return bad | (rd & wr);
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] old,
                                               input logic [31:0] data,
                                               input logic [2:0] sz,
                                               input logic [1:0] off);
      logic [31:0] w;
      w = old;
      case (sz[1:0])
         2'b00:   w[{off, 3'b000} +: 8]      = data[7:0];
         2'b01:   w[{off[1], 4'b0000} +: 16] = data[15:0];
         default: w = data;
      endcase
      return w;
   endfunction

   function automatic logic [WIDTH-1:0] load_extend(input logic [31:0] word,
                                                    input logic [2:0] sz,
                                                    input logic [1:0] off);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [WIDTH-1:0]   r;
      b = word[{off, 3'b000} +: 8];
      h = word[{off[1], 4'b0000} +: 16];
      case (sz)
         3'b000:  r = WIDTH'(b);
         3'b001:  r = WIDTH'(h);
         3'b100:  r = WIDTH'($unsigned(b));
         3'b101:  r = WIDTH'($unsigned(h));
         default: r = WIDTH'(word);
      endcase
      return r;
   endfunction

   assign req = MemRead | MemWrite;

   // With LATENCY==1 the commit edge is the capture edge, so the access is
   // taken straight from the inputs while IDLE and from the captured copy
   // otherwise.
   assign acc_addr  = (state == IDLE) ? Addr      : addr_q;
   assign acc_wdata = (state == IDLE) ? WriteData : wdata_q;
   assign acc_size  = (state == IDLE) ? Size      : size_q;
   assign acc_rd    = (state == IDLE) ? MemRead   : rd_q;
   assign acc_wr    = (state == IDLE) ? MemWrite  : wr_q;

   assign acc_idx   = acc_addr[AW+1:2];
   assign acc_off   = acc_addr[1:0];
   assign acc_word  = mem[acc_idx];
   assign acc_bad   = is_bad(acc_rd, acc_wr, acc_size, acc_off);

   assign unused_bits = ^{acc_addr, acc_wdata};

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stall     = 1'b0;
      case (state)
         IDLE: begin
            stall = req;
            if (req) begin
               cnt_nxt   = 4'(LATENCY - 1);
               state_nxt = (LATENCY == 1) ? DONE : WAIT;
            end
         end
         WAIT: begin
            stall   = 1'b1;
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign commit = (state_nxt == DONE) && (state != DONE);

   // Control and result registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         ReadData <= '0;
         Fault    <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         Fault <= commit & acc_bad;
         if (commit) begin
            if (acc_bad)     ReadData <= '0;
            else if (acc_rd) ReadData <= load_extend(acc_word, acc_size, acc_off);
         end
      end
   end

   // Request capture
   always_ff @(posedge clk) begin
      if (state == IDLE && req) begin
         addr_q  <= Addr;
         wdata_q <= WriteData;
         size_q  <= Size;
         rd_q    <= MemRead;
         wr_q    <= MemWrite;
      end
   end

   // Array write at commit; a reset during the access blocks the write.
   always_ff @(posedge clk) begin
      if (commit && acc_wr && !acc_bad && !reset)
         mem[acc_idx] <= store_merge(acc_word, acc_wdata[31:0], acc_size, acc_off);
   end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder
//   Directed bench for data_memory_responder. Two instances are used:
//   u2 (LATENCY=2) for the functional vectors and u3 (LATENCY=3) for the
//   mid-access reset case. Shared request signals are gated per instance.
module tb_data_memory_responder;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset2, reset3;
   logic        mr, mw, sel;
   logic [2:0]  size;
   logic [31:0] addr, wdata;
   logic        mr2, mw2, mr3, mw3;
   logic [31:0] rd2, rd3;
   logic        stall2, stall3, fault2, fault3;

   int checks = 0;
   int errors = 0;

   assign mr2 = mr & ~sel;
   assign mw2 = mw & ~sel;
   assign mr3 = mr & sel;
   assign mw3 = mw & sel;

   data_memory_responder #(.WIDTH(32), .DEPTH(256), .LATENCY(2)) u2 (
      .clk(clk), .reset(reset2), .MemRead(mr2), .MemWrite(mw2), .Size(size),
      .Addr(addr), .WriteData(wdata), .ReadData(rd2), .stall(stall2), .Fault(fault2));

   data_memory_responder #(.WIDTH(32), .DEPTH(256), .LATENCY(3)) u3 (
      .clk(clk), .reset(reset3), .MemRead(mr3), .MemWrite(mw3), .Size(size),
      .Addr(addr), .WriteData(wdata), .ReadData(rd3), .stall(stall3), .Fault(fault3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One complete access; returns stall cycle count, and ReadData/Fault
   // sampled in the DONE cycle, plus whether Fault rose during the stall.
   task automatic access(input logic s, input logic r, input logic w,
                         input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output int ns,
                         output logic [31:0] rdv, output logic fv,
                         output logic fstall);
      @(posedge clk); #1;
      sel = s; mr = r; mw = w; size = sz; addr = a; wdata = wd; #1;
      ns = 0;
      fstall = 1'b0;
      while ((s ? stall3 : stall2) && ns < 20) begin
         fstall = fstall | (s ? fault3 : fault2);
         ns++;
         @(posedge clk); #1;
         mr = 1'b0; mw = 1'b0; #1;
      end
      rdv = s ? rd3 : rd2;
      fv  = s ? fault3 : fault2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int          ns;
      logic [31:0] rdv;
      logic        fv, fs;
      logic [5:0]  pat;
      logic [31:0] rdh;

      reset2 = 1'b1; reset3 = 1'b1;
      mr = 1'b0; mw = 1'b0; sel = 1'b0; size = 3'b000; addr = '0; wdata = '0;
      repeat (3) @(posedge clk);
      #2 reset2 = 1'b0; reset3 = 1'b0;
      #1;
      chk("reset_rd", rd2, 32'h0);
      chk("reset_stall", {31'b0, stall2}, 32'h0);
      chk("reset_fault", {31'b0, fault2}, 32'h0);

      // SW 0x10 = DEADBEEF
      access(0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, ns, rdv, fv, fs);
      chk("sw_stall", ns, 2);
      chk("sw_fault", {31'b0, fv}, 32'h0);
      chk("sw_rd_unchanged", rdv, 32'h0);

      access(0, 1, 0, 3'b010, 32'h10, 32'h0, ns, rdv, fv, fs);
      chk("lw_stall", ns, 2);
      chk("lw", rdv, 32'hDEADBEEF);

      access(0, 1, 0, 3'b000, 32'h13, 32'h0, ns, rdv, fv, fs);
      chk("lb", rdv, 32'hFFFFFFDE);
      access(0, 1, 0, 3'b100, 32'h13, 32'h0, ns, rdv, fv, fs);
      chk("lbu", rdv, 32'h000000DE);
      access(0, 1, 0, 3'b001, 32'h10, 32'h0, ns, rdv, fv, fs);
      chk("lh", rdv, 32'hFFFFBEEF);
      access(0, 1, 0, 3'b101, 32'h12, 32'h0, ns, rdv, fv, fs);
      chk("lhu", rdv, 32'h0000DEAD);

      // SB 0x11 = 55; ReadData must hold the last load result
      access(0, 0, 1, 3'b000, 32'h11, 32'h00000055, ns, rdv, fv, fs);
      chk("sb_rd_hold", rdv, 32'h0000DEAD);
      access(0, 1, 0, 3'b010, 32'h10, 32'h0, ns, rdv, fv, fs);
      chk("lw_after_sb", rdv, 32'hDEAD55EF);

      // Misaligned LW
      access(0, 1, 0, 3'b010, 32'h12, 32'h0, ns, rdv, fv, fs);
      chk("mis_stall", ns, 2);
      chk("mis_fault", {31'b0, fv}, 32'h1);
      chk("mis_fault_early", {31'b0, fs}, 32'h0);
      chk("mis_rd", rdv, 32'h0);
      @(posedge clk); #1;
      chk("mis_fault_pulse", {31'b0, fault2}, 32'h0);
      access(0, 1, 0, 3'b010, 32'h10, 32'h0, ns, rdv, fv, fs);
      chk("lw_after_mis", rdv, 32'hDEAD55EF);
      chk("lw_after_mis_fault", {31'b0, fv}, 32'h0);

      // SH 0x12 = A5A5
      access(0, 0, 1, 3'b001, 32'h12, 32'h0000A5A5, ns, rdv, fv, fs);
      access(0, 1, 0, 3'b010, 32'h10, 32'h0, ns, rdv, fv, fs);
      chk("lw_after_sh", rdv, 32'hA5A555EF);

      // Unsupported size, then read+write together
      access(0, 1, 0, 3'b011, 32'h10, 32'h0, ns, rdv, fv, fs);
      chk("badsize_fault", {31'b0, fv}, 32'h1);
      chk("badsize_rd", rdv, 32'h0);
      access(0, 1, 1, 3'b010, 32'h10, 32'h0, ns, rdv, fv, fs);
      chk("rw_fault", {31'b0, fv}, 32'h1);
      chk("rw_stall", ns, 2);
      access(0, 1, 0, 3'b010, 32'h10, 32'h0, ns, rdv, fv, fs);
      chk("lw_after_rw", rdv, 32'hA5A555EF);

      // Held request with aliased address 4*DEPTH+8 -> word 2
      access(0, 0, 1, 3'b010, 32'h8, 32'h0BADF00D, ns, rdv, fv, fs);
      @(posedge clk); #1;
      sel = 1'b0; mr = 1'b1; mw = 1'b0; size = 3'b010; addr = 32'h408; #1;
      pat = '0;
      rdh = '0;
      for (int i = 0; i < 6; i++) begin
         pat[5-i] = stall2;
         if (i == 2) rdh = rd2;
         @(posedge clk); #1;
         if (i == 3) mr = 1'b0;
         #1;
      end
      chk("held_stall_pattern", {26'b0, pat}, 32'h36);
      chk("alias_rd", rdh, 32'h0BADF00D);

      // LATENCY=3 instance: reset in the second stall cycle of a store
      access(1, 0, 1, 3'b010, 32'h20, 32'hCAFEF00D, ns, rdv, fv, fs);
      chk("l3_sw_stall", ns, 3);
      access(1, 1, 0, 3'b010, 32'h20, 32'h0, ns, rdv, fv, fs);
      chk("l3_lw", rdv, 32'hCAFEF00D);
      @(posedge clk); #1;
      sel = 1'b1; mw = 1'b1; mr = 1'b0; size = 3'b010; addr = 32'h20; wdata = 32'h12345678; #1;
      chk("l3_stall_c1", {31'b0, stall3}, 32'h1);
      @(posedge clk); #1;
      mw = 1'b0; #1;
      chk("l3_stall_c2", {31'b0, stall3}, 32'h1);
      reset3 = 1'b1; #1;
      chk("l3_reset_stall", {31'b0, stall3}, 32'h0);
      chk("l3_reset_rd", rd3, 32'h0);
      chk("l3_reset_fault", {31'b0, fault3}, 32'h0);
      #1 reset3 = 1'b0;
      access(1, 1, 0, 3'b010, 32'h20, 32'h0, ns, rdv, fv, fs);
      chk("l3_lw_after_reset_stall", ns, 3);
      chk("l3_lw_after_reset", rdv, 32'hCAFEF00D);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
